// File: rtl/sd_to_binary_serial_pkg.sv
// Shared definitions for the serial signed-digit to binary converter:
// FSM state encodings, signed-digit encodings and the default width.
package sd_to_binary_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CONV = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Signed-digit encodings, written as {pos, neg}
  localparam logic [1:0] SD_ZERO    = 2'b00;
  localparam logic [1:0] SD_POS     = 2'b10;
  localparam logic [1:0] SD_NEG     = 2'b01;
  localparam logic [1:0] SD_ILLEGAL = 2'b11;

  // An illegal digit (both bits set) is treated as zero arithmetically.
  function automatic logic [1:0] sd_legalize(input logic [1:0] digit);
    return (digit == SD_ILLEGAL) ? SD_ZERO : digit;
  endfunction

endpackage

// File: rtl/sd_to_binary_serial_sd_digit_sub.sv
// One-digit p - n - b subtractor used to fold a signed digit and the
// running borrow into one result bit and the next borrow.
module sd_digit_sub (
  input  logic p_i,
  input  logic n_i,
  input  logic b_i,
  output logic r_o,
  output logic b_o
);

  assign r_o = p_i ^ n_i ^ b_i;
  assign b_o = (~p_i & n_i) | (~p_i & b_i) | (n_i & b_i);

endmodule

// File: rtl/sd_to_binary_serial.sv
// Serial signed-digit to two's-complement converter. An accepted operand
// is walked LSB first, one digit per clock, through a single digit
// subtractor; the final borrow becomes the sign bit of the result.
module sd_to_binary_serial
  import sd_to_binary_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pos,
  input  logic [WIDTH-1:0] in_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_value,
  output logic             out_err,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] neg_q, neg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [1:0] digit;
  logic       digit_illegal;
  logic       r_bit;
  logic       b_next;

  // Current digit always sits in bit 0 of the shifting operand registers.
  assign digit         = sd_legalize({pos_q[0], neg_q[0]});
  assign digit_illegal = ({pos_q[0], neg_q[0]} == SD_ILLEGAL);

  sd_digit_sub u_digit (
    .p_i (digit[1]),
    .n_i (digit[0]),
    .b_i (borrow_q),
    .r_o (r_bit),
    .b_o (b_next)
  );

  // Next-state logic: capture in IDLE, one digit per clock in CONV, hold in DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    pos_d    = pos_q;
    neg_d    = neg_q;
    res_d    = res_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pos_d    = in_pos;
          neg_d    = in_neg;
          idx_d    = '0;
          borrow_d = 1'b0;
          res_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        // Result bits enter at the top and reach their final position
        // after WIDTH shifts.
        res_d    = {r_bit, res_q[WIDTH-1:1]};
        borrow_d = b_next;
        err_d    = err_q | digit_illegal;
        pos_d    = pos_q >> 1;
        neg_d    = neg_q >> 1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      pos_q    <= '0;
      neg_q    <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      pos_q    <= pos_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CONV) || (state_q == ST_DONE);
  assign out_value = {borrow_q, res_q};
  assign out_err   = err_q;

endmodule
